// File: rtl/apb_mem_slave_v2_if.sv
// APB4 master-side and memory REQ/GRANT signals between the bridge and its neighbours.
interface apb_mem_slave_v2_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    // APB side
    logic [ADDR_WIDTH-1:0] PADDR_m_s;
    logic                  PWRITE_m_s;
    logic                  PSEL_m_s;
    logic                  PENABLE_m_s;
    logic [DATA_WIDTH-1:0] PWDATA_m_s;
    logic [STRB_W-1:0]     PSTRB_m_s;
    logic                  PREADY_s_m;
    logic                  PSLVERR_s_m;
    logic [DATA_WIDTH-1:0] PRDATA_s_m;

    // Memory side
    logic [ADDR_WIDTH-1:0] ADDR_p_e;
    logic                  WRITE_p_e;
    logic [DATA_WIDTH-1:0] WDATA_p_e;
    logic [STRB_W-1:0]     STRB_p_e;
    logic                  REQ_p_e;
    logic                  GRANT_e_p;
    logic [DATA_WIDTH-1:0] RDATA_e_p;

    // Bridge view
    modport slave (
        input  PADDR_m_s, PWRITE_m_s, PSEL_m_s, PENABLE_m_s, PWDATA_m_s, PSTRB_m_s,
        output PREADY_s_m, PSLVERR_s_m, PRDATA_s_m,
        output ADDR_p_e, WRITE_p_e, WDATA_p_e, STRB_p_e, REQ_p_e,
        input  GRANT_e_p, RDATA_e_p
    );

    // Environment view: APB master plus memory responder
    modport master (
        output PADDR_m_s, PWRITE_m_s, PSEL_m_s, PENABLE_m_s, PWDATA_m_s, PSTRB_m_s,
        input  PREADY_s_m, PSLVERR_s_m, PRDATA_s_m,
        input  ADDR_p_e, WRITE_p_e, WDATA_p_e, STRB_p_e, REQ_p_e,
        output GRANT_e_p, RDATA_e_p
    );
endinterface

// File: rtl/apb_mem_slave_v2.sv
// APB4 slave that forwards checked transfers onto a memory REQ/GRANT port,
// with read-only window, alignment/range checks, grant timeout and error counter.
module apb_mem_slave_v2 #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    apb_mem_slave_v2_if.slave     bus,
    input  logic [ADDR_WIDTH-1:0] MaxAddr,
    input  logic [ADDR_WIDTH-1:0] RoBase,
    output logic [ERR_CNT_W-1:0]  ErrCnt
);

    localparam int unsigned STRB_W  = DATA_WIDTH / 8;
    localparam int unsigned TO_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic                  req_q, req_d;
    logic [ERR_CNT_W-1:0]  errcnt_q, errcnt_d;
    logic [TO_W-1:0]       tocnt_q, tocnt_d;
    logic                  abort_q, abort_d;

    logic setup_c;
    logic chk_err_c;
    logic aborting_c;
    logic enter_err_c;

    // Setup-phase decode and address checks
    always_comb begin
        setup_c   = bus.PSEL_m_s && !bus.PENABLE_m_s;
        chk_err_c = (bus.PADDR_m_s > MaxAddr)
                 || (|(bus.PADDR_m_s & ALIGN_MASK))
                 || (bus.PWRITE_m_s && (bus.PADDR_m_s >= RoBase));
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        prdata_d    = '0;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        req_d       = req_q;
        errcnt_d    = errcnt_q;
        tocnt_d     = tocnt_q;
        abort_d     = abort_q;
        aborting_c  = 1'b0;
        enter_err_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (setup_c) begin
                    addr_d  = bus.PADDR_m_s;
                    write_d = bus.PWRITE_m_s;
                    if (bus.PWRITE_m_s) begin
                        wdata_d = bus.PWDATA_m_s;
                        strb_d  = bus.PSTRB_m_s;
                    end else begin
                        strb_d  = '1;
                    end
                    tocnt_d = '0;
                    abort_d = 1'b0;
                    if (chk_err_c) begin
                        state_d     = S_ERR;
                        pready_d    = 1'b1;
                        pslverr_d   = 1'b1;
                        enter_err_c = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                    end
                end
            end

            S_REQ: begin
                // A master that drops PSEL gets no response, but the memory access still finishes
                if (!bus.PSEL_m_s) begin
                    abort_d = 1'b1;
                end
                aborting_c = abort_q || !bus.PSEL_m_s;
                if (bus.GRANT_e_p) begin
                    req_d = 1'b0;
                    if (aborting_c) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_RESP;
                        pready_d = 1'b1;
                        prdata_d = write_q ? '0 : bus.RDATA_e_p;
                    end
                end else if ((TIMEOUT != 0) && (tocnt_q == TO_W'(TO_LAST))) begin
                    req_d = 1'b0;
                    if (aborting_c) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d     = S_ERR;
                        pready_d    = 1'b1;
                        pslverr_d   = 1'b1;
                        enter_err_c = 1'b1;
                    end
                end else begin
                    tocnt_d = tocnt_q + TO_W'(1);
                end
            end

            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (enter_err_c && (errcnt_q != '1)) begin
            errcnt_d = errcnt_q + ERR_CNT_W'(1);
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            req_q     <= 1'b0;
            errcnt_q  <= '0;
            tocnt_q   <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            req_q     <= req_d;
            errcnt_q  <= errcnt_d;
            tocnt_q   <= tocnt_d;
            abort_q   <= abort_d;
        end
    end

    assign bus.PREADY_s_m  = pready_q;
    assign bus.PSLVERR_s_m = pslverr_q;
    assign bus.PRDATA_s_m  = prdata_q;
    assign bus.ADDR_p_e    = addr_q;
    assign bus.WRITE_p_e   = write_q;
    assign bus.WDATA_p_e   = wdata_q;
    assign bus.STRB_p_e    = strb_q;
    assign bus.REQ_p_e     = req_q;
    assign ErrCnt          = errcnt_q;

endmodule

// File: tb/tb_apb_mem_slave_v2.sv
// Directed bench for apb_mem_slave_v2: vector table plus abort and reset sequences.
module tb_apb_mem_slave_v2;

    logic        clk;
    logic        rst;
    logic [31:0] max_addr;
    logic [31:0] ro_base;
    logic [1:0]  err_cnt;

    int n_cmp;
    int n_bad;

    apb_mem_slave_v2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_mem_slave_v2 #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (4),
        .ERR_CNT_W (2)
    ) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus),
        .MaxAddr(max_addr),
        .RoBase (ro_base),
        .ErrCnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          gnt;      // REQ cycle (1-based) in which grant is given; 0 = never
        logic [31:0] rdata;
        logic        e_err;
        int          e_lat;    // cycles from setup to PREADY
        int          e_reqc;   // cycles REQ_p_e is high
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_prdata;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Runs one APB transfer from setup (current cycle) until PREADY, then checks it
    task automatic run_xfer(input string tag, input vec_t v);
        int          reqc;
        int          lat;
        logic        seen;
        logic        got_err;
        logic [31:0] got_rd;
        logic [31:0] got_addr;
        logic        got_wr;
        logic [3:0]  got_strb;
        logic [31:0] got_wdata;
        reqc = 0; lat = 0; seen = 1'b0; got_err = 1'b0; got_rd = '0;
        got_addr = '0; got_wr = 1'b0; got_strb = '0; got_wdata = '0;
        bus.PSEL_m_s    = 1'b1;
        bus.PENABLE_m_s = 1'b0;
        bus.PWRITE_m_s  = v.wr;
        bus.PADDR_m_s   = v.addr;
        bus.PWDATA_m_s  = v.wdata;
        bus.PSTRB_m_s   = v.strb;
        bus.GRANT_e_p   = 1'b0;
        for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
            @(posedge clk); #1;
            bus.PENABLE_m_s = 1'b1;
            bus.GRANT_e_p   = 1'b0;
            if (cyc == 1) begin
                got_addr  = bus.ADDR_p_e;
                got_wr    = bus.WRITE_p_e;
                got_strb  = bus.STRB_p_e;
                got_wdata = bus.WDATA_p_e;
            end
            if (bus.PREADY_s_m) begin
                seen    = 1'b1;
                lat     = cyc;
                got_err = bus.PSLVERR_s_m;
                got_rd  = bus.PRDATA_s_m;
            end else if (bus.REQ_p_e) begin
                reqc++;
                if (reqc == v.gnt) begin
                    bus.GRANT_e_p = 1'b1;
                    bus.RDATA_e_p = v.rdata;
                end
            end
        end
        bus.PSEL_m_s    = 1'b0;
        bus.PENABLE_m_s = 1'b0;
        bus.GRANT_e_p   = 1'b0;
        chk({tag, ".latency"}, 64'(lat), 64'(v.e_lat));
        chk({tag, ".req_cycles"}, 64'(reqc), 64'(v.e_reqc));
        chk({tag, ".pslverr"}, 64'(got_err), 64'(v.e_err));
        chk({tag, ".prdata"}, 64'(got_rd), 64'(v.e_prdata));
        chk({tag, ".addr"}, 64'(got_addr), 64'(v.addr));
        chk({tag, ".write"}, 64'(got_wr), 64'(v.wr));
        chk({tag, ".strb"}, 64'(got_strb), 64'(v.e_strb));
        chk({tag, ".wdata"}, 64'(got_wdata), 64'(v.e_wdata));
        @(posedge clk); #1;
        chk({tag, ".pready_low"}, 64'(bus.PREADY_s_m), 64'(0));
        chk({tag, ".prdata_zero"}, 64'(bus.PRDATA_s_m), 64'(0));
        chk({tag, ".errcnt"}, 64'(err_cnt), 64'(v.e_cnt));
    endtask

    initial begin
        vec_t v;
        n_cmp = 0;
        n_bad = 0;
        max_addr = 32'hFF;
        ro_base  = 32'hF0;
        rst = 1'b1;
        bus.PSEL_m_s = 1'b0; bus.PENABLE_m_s = 1'b0; bus.PWRITE_m_s = 1'b0;
        bus.PADDR_m_s = '0; bus.PWDATA_m_s = '0; bus.PSTRB_m_s = '0;
        bus.GRANT_e_p = 1'b0; bus.RDATA_e_p = '0;

        //          wr    addr    wdata         strb   gnt rdata        err  lat reqc e_strb  e_wdata       e_prdata      cnt
        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'b0011, 2, 32'h0,        1'b0, 3, 2, 4'b0011, 32'hDEADBEEF, 32'h0,        2'd0};
        vecs[1]  = '{1'b0, 32'h20,  32'hCAFEF00D, 4'b0000, 1, 32'h12345678, 1'b0, 2, 1, 4'b1111, 32'hDEADBEEF, 32'h12345678, 2'd0};
        vecs[2]  = '{1'b1, 32'hF4,  32'h11111111, 4'b1111, 1, 32'h0,        1'b1, 1, 0, 4'b1111, 32'h11111111, 32'h0,        2'd1};
        vecs[3]  = '{1'b0, 32'h104, 32'h22222222, 4'b0000, 1, 32'h0,        1'b1, 1, 0, 4'b1111, 32'h11111111, 32'h0,        2'd2};
        vecs[4]  = '{1'b0, 32'h22,  32'h22222222, 4'b0000, 1, 32'h0,        1'b1, 1, 0, 4'b1111, 32'h11111111, 32'h0,        2'd3};
        vecs[5]  = '{1'b0, 32'h30,  32'h0,        4'b0000, 0, 32'hFFFFFFFF, 1'b1, 5, 4, 4'b1111, 32'h11111111, 32'h0,        2'd3};
        vecs[6]  = '{1'b1, 32'h40,  32'h0BADC0DE, 4'b1100, 4, 32'h0,        1'b0, 5, 4, 4'b1100, 32'h0BADC0DE, 32'h0,        2'd3};
        vecs[7]  = '{1'b0, 32'hF0,  32'h0,        4'b0000, 3, 32'hA5A55A5A, 1'b0, 4, 3, 4'b1111, 32'h0BADC0DE, 32'hA5A55A5A, 2'd3};
        vecs[8]  = '{1'b0, 32'hFC,  32'h0,        4'b0000, 1, 32'h00C0FFEE, 1'b0, 2, 1, 4'b1111, 32'h0BADC0DE, 32'h00C0FFEE, 2'd3};
        vecs[9]  = '{1'b1, 32'h100, 32'h33333333, 4'b0101, 1, 32'h0,        1'b1, 1, 0, 4'b0101, 32'h33333333, 32'h0,        2'd3};
        vecs[10] = '{1'b1, 32'hEC,  32'h44444444, 4'b1001, 1, 32'h0,        1'b0, 2, 1, 4'b1001, 32'h44444444, 32'h0,        2'd3};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset.pready", 64'(bus.PREADY_s_m), 64'(0));
        chk("reset.pslverr", 64'(bus.PSLVERR_s_m), 64'(0));
        chk("reset.req", 64'(bus.REQ_p_e), 64'(0));
        chk("reset.addr", 64'(bus.ADDR_p_e), 64'(0));
        chk("reset.errcnt", 64'(err_cnt), 64'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i]);
        end

        // Master abandons a read while REQ is pending: memory completes, no response
        bus.PSEL_m_s = 1'b1; bus.PENABLE_m_s = 1'b0; bus.PWRITE_m_s = 1'b0;
        bus.PADDR_m_s = 32'h50;
        @(posedge clk); #1;
        chk("abort.req_t1", 64'(bus.REQ_p_e), 64'(1));
        bus.PSEL_m_s = 1'b0;
        @(posedge clk); #1;
        chk("abort.req_held", 64'(bus.REQ_p_e), 64'(1));
        bus.GRANT_e_p = 1'b1; bus.RDATA_e_p = 32'h77777777;
        @(posedge clk); #1;
        bus.GRANT_e_p = 1'b0;
        chk("abort.no_pready", 64'(bus.PREADY_s_m), 64'(0));
        chk("abort.req_drop", 64'(bus.REQ_p_e), 64'(0));
        chk("abort.errcnt", 64'(err_cnt), 64'(3));
        v = '{1'b0, 32'h0, 32'h0, 4'b0000, 1, 32'h5A5A0001, 1'b0, 2, 1, 4'b1111, 32'h44444444, 32'h5A5A0001, 2'd3};
        run_xfer("after_abort", v);

        // Reset in the middle of a pending write
        bus.PSEL_m_s = 1'b1; bus.PENABLE_m_s = 1'b0; bus.PWRITE_m_s = 1'b1;
        bus.PADDR_m_s = 32'h60; bus.PWDATA_m_s = 32'h66666666; bus.PSTRB_m_s = 4'b1111;
        @(posedge clk); #1;
        chk("midrst.req_t1", 64'(bus.REQ_p_e), 64'(1));
        bus.PENABLE_m_s = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst.req", 64'(bus.REQ_p_e), 64'(0));
        chk("midrst.pready", 64'(bus.PREADY_s_m), 64'(0));
        chk("midrst.pslverr", 64'(bus.PSLVERR_s_m), 64'(0));
        chk("midrst.addr", 64'(bus.ADDR_p_e), 64'(0));
        chk("midrst.write", 64'(bus.WRITE_p_e), 64'(0));
        chk("midrst.wdata", 64'(bus.WDATA_p_e), 64'(0));
        chk("midrst.strb", 64'(bus.STRB_p_e), 64'(0));
        chk("midrst.errcnt", 64'(err_cnt), 64'(0));
        rst = 1'b0;
        bus.PSEL_m_s = 1'b0; bus.PENABLE_m_s = 1'b0;
        @(posedge clk); #1;
        chk("midrst.idle_req", 64'(bus.REQ_p_e), 64'(0));
        v = '{1'b0, 32'h8, 32'h0, 4'b0000, 2, 32'hBEEF0008, 1'b0, 3, 2, 4'b1111, 32'h0, 32'hBEEF0008, 2'd0};
        run_xfer("after_reset", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
